// File: rtl/cp0_defs.sv
`default_nettype none
// cp0_defs: shared CP0 register numbers, field positions and exception codes.
// Revision 1.0
package cp0_defs;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_EBASE    = 5'd15;

  localparam logic [2:0] SEL_DEFAULT  = 3'd0;
  localparam logic [2:0] SEL_EBASE    = 3'd1;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IV     = 23;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic       bev;
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  function automatic logic reg_hit(input logic [4:0] addr, input logic [2:0] sel,
                                   input logic [4:0] reg_no, input logic [2:0] reg_sel);
    return (addr == reg_no) && (sel == reg_sel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_regs_if.sv
`default_nettype none
// cp0_regs_if: pipeline/exception-unit side bundle of the CP0 register file.
// Revision 1.0
interface cp0_regs_if;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic        exp_we;
  logic        exp_clean_exl;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_bad_vaddr;
  logic        exp_badv_we;
  logic [7:0]  exp_asid;
  logic        exp_asid_we;
  logic [4:0]  hw_int_in;
  logic [5:0]  hardware_int;
  logic [1:0]  software_int;
  logic [7:0]  interrupt_mask;
  logic        allow_int;
  logic        special_int_vec;
  logic        boot_exp_vec;
  logic        exl;
  logic [19:0] ebase;
  logic [31:0] epc;
  logic [7:0]  asid;

  modport master (
    output rd_addr, rd_sel, we, wr_addr, wr_sel, wr_data,
           exp_we, exp_clean_exl, exp_epc, exp_bd, exp_code,
           exp_bad_vaddr, exp_badv_we, exp_asid, exp_asid_we, hw_int_in,
    input  rd_data, hardware_int, software_int, interrupt_mask, allow_int,
           special_int_vec, boot_exp_vec, exl, ebase, epc, asid
  );

  modport slave (
    input  rd_addr, rd_sel, we, wr_addr, wr_sel, wr_data,
           exp_we, exp_clean_exl, exp_epc, exp_bd, exp_code,
           exp_bad_vaddr, exp_badv_we, exp_asid, exp_asid_we, hw_int_in,
    output rd_data, hardware_int, software_int, interrupt_mask, allow_int,
           special_int_vec, boot_exp_vec, exl, ebase, epc, asid
  );
endinterface
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// cp0_timer: free-running Count, Compare and the sticky timer-interrupt flag TI.
// Revision 1.0
module cp0_timer (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        count_we,
  input  wire logic        compare_we,
  input  wire logic [31:0] wr_data,
  output logic [31:0]      count,
  output logic [31:0]      compare,
  output logic             ti
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      count <= count_we ? wr_data : count + 32'd1;
      if (compare_we) begin
        compare <= wr_data;
      end
      // A Compare write acknowledges the interrupt even if a match lands on the same edge.
      if (compare_we) begin
        ti <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cp0_regs.sv
`default_nettype none
// cp0_regs: CP0 register file with exception capture, timer interrupt and MFC0/MTC0 access.
// Revision 1.0
module cp0_regs
  import cp0_defs::*;
#(
  parameter logic [19:0] EBASE_RST = 20'h80000
) (
  input wire logic  clk,
  input wire logic  rst,
  cp0_regs_if.slave bus
);

  status_t     status;
  logic        bd;
  logic        iv;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc_q;
  logic [31:0] bad_vaddr;
  logic [18:0] vpn2;
  logic [7:0]  asid_q;
  logic [17:0] ebase_q;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_entryhi, wr_ebase;
  logic exp_first;

  assign wr_count   = bus.we && reg_hit(bus.wr_addr, bus.wr_sel, CP0_COUNT,   SEL_DEFAULT);
  assign wr_compare = bus.we && reg_hit(bus.wr_addr, bus.wr_sel, CP0_COMPARE, SEL_DEFAULT);
  assign wr_status  = bus.we && reg_hit(bus.wr_addr, bus.wr_sel, CP0_STATUS,  SEL_DEFAULT);
  assign wr_cause   = bus.we && reg_hit(bus.wr_addr, bus.wr_sel, CP0_CAUSE,   SEL_DEFAULT);
  assign wr_epc     = bus.we && reg_hit(bus.wr_addr, bus.wr_sel, CP0_EPC,     SEL_DEFAULT);
  assign wr_entryhi = bus.we && reg_hit(bus.wr_addr, bus.wr_sel, CP0_ENTRYHI, SEL_DEFAULT);
  assign wr_ebase   = bus.we && reg_hit(bus.wr_addr, bus.wr_sel, CP0_EBASE,   SEL_EBASE);

  // Only an exception taken outside EXL records the return point; nested ones keep it.
  assign exp_first = bus.exp_we && !status.exl;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wr_data    (bus.wr_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= '{bev: 1'b1, im: 8'd0, exl: 1'b0, ie: 1'b0};
      bd        <= 1'b0;
      iv        <= 1'b0;
      ip_sw     <= 2'd0;
      exc_code  <= 5'd0;
      epc_q     <= 32'd0;
      bad_vaddr <= 32'd0;
      vpn2      <= 19'd0;
      asid_q    <= 8'd0;
      ebase_q   <= EBASE_RST[17:0];
    end else begin
      if (wr_status) begin
        status.bev <= bus.wr_data[ST_BEV];
        status.im  <= bus.wr_data[ST_IM_LO +: 8];
        status.ie  <= bus.wr_data[ST_IE];
      end

      if (bus.exp_we) begin
        status.exl <= 1'b1;
      end else if (bus.exp_clean_exl) begin
        status.exl <= 1'b0;
      end else if (wr_status) begin
        status.exl <= bus.wr_data[ST_EXL];
      end

      if (wr_cause) begin
        iv    <= bus.wr_data[CA_IV];
        ip_sw <= bus.wr_data[CA_IP_LO +: 2];
      end

      if (bus.exp_we) begin
        exc_code <= bus.exp_code;
      end

      if (exp_first) begin
        bd    <= bus.exp_bd;
        epc_q <= bus.exp_epc;
      end else if (wr_epc) begin
        epc_q <= bus.wr_data;
      end

      if (bus.exp_we && bus.exp_badv_we) begin
        bad_vaddr <= bus.exp_bad_vaddr;
      end

      if (wr_entryhi) begin
        vpn2 <= bus.wr_data[31:13];
      end

      if (bus.exp_we && bus.exp_asid_we) begin
        asid_q <= bus.exp_asid;
      end else if (wr_entryhi) begin
        asid_q <= bus.wr_data[7:0];
      end

      if (wr_ebase) begin
        ebase_q <= bus.wr_data[29:12];
      end
    end
  end

  always_comb begin
    bus.rd_data = 32'd0;
    if (bus.rd_sel == SEL_DEFAULT) begin
      case (bus.rd_addr)
        CP0_BADVADDR: bus.rd_data = bad_vaddr;
        CP0_COUNT:    bus.rd_data = count;
        CP0_ENTRYHI:  bus.rd_data = {vpn2, 5'd0, asid_q};
        CP0_COMPARE:  bus.rd_data = compare;
        CP0_STATUS:   bus.rd_data = {9'd0, status.bev, 6'd0, status.im, 6'd0, status.exl, status.ie};
        CP0_CAUSE:    bus.rd_data = {bd, ti, 6'd0, iv, 7'd0, ti, bus.hw_int_in, ip_sw,
                                     1'b0, exc_code, 2'd0};
        CP0_EPC:      bus.rd_data = epc_q;
        default:      bus.rd_data = 32'd0;
      endcase
    end else if (bus.rd_sel == SEL_EBASE && bus.rd_addr == CP0_EBASE) begin
      bus.rd_data = {2'b10, ebase_q, 12'd0};
    end
  end

  assign bus.hardware_int    = {ti, bus.hw_int_in};
  assign bus.software_int    = ip_sw;
  assign bus.interrupt_mask  = status.im;
  assign bus.allow_int       = status.ie && !status.exl;
  assign bus.special_int_vec = iv;
  assign bus.boot_exp_vec    = status.bev;
  assign bus.exl             = status.exl;
  assign bus.ebase           = {2'b10, ebase_q};
  assign bus.epc             = epc_q;
  assign bus.asid            = asid_q;

endmodule
`default_nettype wire
